// File: rtl/sc_psr_cond_pkg.sv
// Shared definitions for the PSR / branch-condition unit: condition codes,
// FSM state encoding and flag bit positions.
package sc_psr_cond_pkg;

    localparam logic [3:0] COND_NEVER  = 4'd0;
    localparam logic [3:0] COND_ALWAYS = 4'd1;
    localparam logic [3:0] COND_EQ     = 4'd2;
    localparam logic [3:0] COND_NE     = 4'd3;
    localparam logic [3:0] COND_CS     = 4'd4;
    localparam logic [3:0] COND_CC     = 4'd5;
    localparam logic [3:0] COND_NEG    = 4'd6;
    localparam logic [3:0] COND_POS    = 4'd7;
    localparam logic [3:0] COND_VS     = 4'd8;
    localparam logic [3:0] COND_VC     = 4'd9;
    localparam logic [3:0] COND_LT     = 4'd10;
    localparam logic [3:0] COND_GE     = 4'd11;
    localparam logic [3:0] COND_LE     = 4'd12;
    localparam logic [3:0] COND_GT     = 4'd13;
    localparam logic [3:0] COND_LEU    = 4'd14;
    localparam logic [3:0] COND_GU     = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    localparam int PSR_C = 0;
    localparam int PSR_V = 1;
    localparam int PSR_Z = 2;
    localparam int PSR_N = 3;

    // ALU flags arrive active-low; the register stores them active-high.
    function automatic logic [3:0] flags_from_inlow(input logic n_l, input logic z_l,
                                                    input logic v_l, input logic c_l);
        logic [3:0] f;
        f        = 4'b0000;
        f[PSR_N] = ~n_l;
        f[PSR_Z] = ~z_l;
        f[PSR_V] = ~v_l;
        f[PSR_C] = ~c_l;
        return f;
    endfunction

endpackage

// File: rtl/sc_psr_cond_if.sv
// Bus bundle between the ALU/control side and the PSR / branch-condition unit.
interface sc_psr_cond_if #(
    parameter int DATAWIDTH_BUS   = 32,
    parameter int DATAWIDTH_COND  = 4,
    parameter int DATAWIDTH_COUNT = 16
);
    logic                       sc_psr_cond_overflow_InLow;
    logic                       sc_psr_cond_carry_InLow;
    logic                       sc_psr_cond_negative_InLow;
    logic                       sc_psr_cond_zero_InLow;
    logic                       sc_psr_cond_SetCode_In;
    logic                       sc_psr_cond_psrWrite_In;
    logic [DATAWIDTH_BUS-1:0]   sc_psr_cond_data_InBus;
    logic                       sc_psr_cond_evalValid_In;
    logic [DATAWIDTH_COND-1:0]  sc_psr_cond_cond_InBus;
    logic                       sc_psr_cond_evalReady_Out;
    logic                       sc_psr_cond_resultValid_Out;
    logic                       sc_psr_cond_taken_Out;
    logic                       sc_psr_cond_resultAck_In;
    logic [DATAWIDTH_BUS-1:0]   sc_psr_cond_psr_OutBus;
    logic [DATAWIDTH_COUNT-1:0] sc_psr_cond_takenCount_OutBus;

    modport master (
        output sc_psr_cond_overflow_InLow, sc_psr_cond_carry_InLow,
               sc_psr_cond_negative_InLow, sc_psr_cond_zero_InLow,
               sc_psr_cond_SetCode_In, sc_psr_cond_psrWrite_In, sc_psr_cond_data_InBus,
               sc_psr_cond_evalValid_In, sc_psr_cond_cond_InBus, sc_psr_cond_resultAck_In,
        input  sc_psr_cond_evalReady_Out, sc_psr_cond_resultValid_Out, sc_psr_cond_taken_Out,
               sc_psr_cond_psr_OutBus, sc_psr_cond_takenCount_OutBus
    );

    modport slave (
        input  sc_psr_cond_overflow_InLow, sc_psr_cond_carry_InLow,
               sc_psr_cond_negative_InLow, sc_psr_cond_zero_InLow,
               sc_psr_cond_SetCode_In, sc_psr_cond_psrWrite_In, sc_psr_cond_data_InBus,
               sc_psr_cond_evalValid_In, sc_psr_cond_cond_InBus, sc_psr_cond_resultAck_In,
        output sc_psr_cond_evalReady_Out, sc_psr_cond_resultValid_Out, sc_psr_cond_taken_Out,
               sc_psr_cond_psr_OutBus, sc_psr_cond_takenCount_OutBus
    );

endinterface

// File: rtl/sc_cond_eval.sv
// Purely combinational branch-condition evaluator over active-high {N,Z,V,C};
// kept standalone so a branch predictor can reuse it.
module sc_cond_eval
    import sc_psr_cond_pkg::*;
(
    input  logic [3:0] flags_s,
    input  logic [3:0] cond_s,
    output logic       taken_s
);

    logic n_s, z_s, v_s, c_s, lt_s, le_s, leu_s;

    assign n_s   = flags_s[PSR_N];
    assign z_s   = flags_s[PSR_Z];
    assign v_s   = flags_s[PSR_V];
    assign c_s   = flags_s[PSR_C];
    assign lt_s  = n_s ^ v_s;
    assign le_s  = z_s | lt_s;
    assign leu_s = c_s | z_s;

    // Condition decode.
    always_comb begin
        taken_s = 1'b0;
        case (cond_s)
            COND_NEVER:  taken_s = 1'b0;
            COND_ALWAYS: taken_s = 1'b1;
            COND_EQ:     taken_s = z_s;
            COND_NE:     taken_s = ~z_s;
            COND_CS:     taken_s = c_s;
            COND_CC:     taken_s = ~c_s;
            COND_NEG:    taken_s = n_s;
            COND_POS:    taken_s = ~n_s;
            COND_VS:     taken_s = v_s;
            COND_VC:     taken_s = ~v_s;
            COND_LT:     taken_s = lt_s;
            COND_GE:     taken_s = ~lt_s;
            COND_LE:     taken_s = le_s;
            COND_GT:     taken_s = ~le_s;
            COND_LEU:    taken_s = leu_s;
            COND_GU:     taken_s = ~leu_s;
            default:     taken_s = 1'b0;
        endcase
    end

endmodule

// File: rtl/sc_psr_cond.sv
// Processor status register with a valid/ready branch-condition evaluator
// and a saturating taken-branch counter.
module sc_psr_cond
    import sc_psr_cond_pkg::*;
#(
    parameter int DATAWIDTH_BUS   = 32,
    parameter int DATAWIDTH_COND  = 4,
    parameter int DATAWIDTH_COUNT = 16
) (
    input logic          sc_psr_cond_CLOCK_50,
    input logic          sc_psr_cond_RESET_InLow,
    sc_psr_cond_if.slave bus
);

    logic [3:0]                 flags_d, flags_q;
    state_e                     state_d, state_q;
    logic                       result_valid_d, result_valid_q;
    logic                       eval_ready_d, eval_ready_q;
    logic                       taken_d, taken_q;
    logic [DATAWIDTH_COUNT-1:0] count_d, count_q;
    logic                       eval_taken_s;
    logic                       unused_data_s;

    // Only the low nibble of the bus carries flag data.
    assign unused_data_s = ^{1'b0, bus.sc_psr_cond_data_InBus[DATAWIDTH_BUS-1:4],
                             bus.sc_psr_cond_cond_InBus[DATAWIDTH_COND-1:0]};

    // The evaluator always sees pre-edge flags, so a coincident flag update
    // only affects later requests.
    sc_cond_eval u_cond_eval (
        .flags_s (flags_q),
        .cond_s  (bus.sc_psr_cond_cond_InBus[3:0]),
        .taken_s (eval_taken_s)
    );

    // Flag register next value: bus write beats ALU set-code.
    always_comb begin
        if (bus.sc_psr_cond_psrWrite_In) begin
            flags_d = bus.sc_psr_cond_data_InBus[3:0];
        end else if (bus.sc_psr_cond_SetCode_In) begin
            flags_d = flags_from_inlow(bus.sc_psr_cond_negative_InLow, bus.sc_psr_cond_zero_InLow,
                                       bus.sc_psr_cond_overflow_InLow, bus.sc_psr_cond_carry_InLow);
        end else begin
            flags_d = flags_q;
        end
    end

    // Handshake FSM, result capture and taken counter.
    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sc_psr_cond_evalValid_In) begin
                    state_d = ST_HOLD;
                    taken_d = eval_taken_s;
                    if (eval_taken_s && (count_q != {DATAWIDTH_COUNT{1'b1}})) begin
                        count_d = count_q + {{(DATAWIDTH_COUNT-1){1'b0}}, 1'b1};
                    end else begin
                        count_d = count_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.sc_psr_cond_resultAck_In) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        result_valid_d = (state_d == ST_HOLD);
        eval_ready_d   = (state_d == ST_IDLE);
    end

    // State and output registers; reset clears the result asynchronously.
    always_ff @(posedge sc_psr_cond_CLOCK_50 or negedge sc_psr_cond_RESET_InLow) begin
        if (!sc_psr_cond_RESET_InLow) begin
            flags_q        <= 4'b0000;
            state_q        <= ST_IDLE;
            result_valid_q <= 1'b0;
            eval_ready_q   <= 1'b1;
            taken_q        <= 1'b0;
            count_q        <= {DATAWIDTH_COUNT{1'b0}};
        end else begin
            flags_q        <= flags_d;
            state_q        <= state_d;
            result_valid_q <= result_valid_d;
            eval_ready_q   <= eval_ready_d;
            taken_q        <= taken_d;
            count_q        <= count_d;
        end
    end

    assign bus.sc_psr_cond_evalReady_Out     = eval_ready_q;
    assign bus.sc_psr_cond_resultValid_Out   = result_valid_q;
    assign bus.sc_psr_cond_taken_Out         = taken_q;
    assign bus.sc_psr_cond_psr_OutBus        = {{(DATAWIDTH_BUS-4){1'b0}}, flags_q};
    assign bus.sc_psr_cond_takenCount_OutBus = count_q;

endmodule
